// File: rtl/ws2812_spi_pkg.sv
// ws2812_spi_pkg: opcodes, sequencer states, header and status word layout for the SPI command path.
package ws2812_spi_pkg;
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_READ   = 4'h2;
    localparam logic [3:0] OP_SHOW   = 4'h3;
    localparam logic [3:0] OP_STATUS = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_RD_FETCH,
        S_RD_LOAD,
        S_RD_DATA,
        S_DISCARD
    } state_t;

    localparam int HDR_OP_HI   = 23;
    localparam int HDR_OP_LO   = 20;
    localparam int HDR_ADDR_HI = 19;
    localparam int HDR_ADDR_LO = 8;
    localparam int HDR_CNT_HI  = 7;
    localparam int HDR_CNT_LO  = 0;

    localparam logic [3:0] STAT_TAG = 4'hA;
    localparam int ST_TAG_HI  = 23;
    localparam int ST_TAG_LO  = 20;
    localparam int ST_OVF     = 19;
    localparam int ST_ADDR    = 18;
    localparam int ST_OP      = 17;
    localparam int ST_BUSY    = 16;
    localparam int ST_SHOW    = 15;
    localparam int ST_LEDS_HI = 11;

    function automatic logic [23:0] status_word(input logic ovf, input logic addr_e, input logic op_e,
                                                input logic busy, input logic show, input logic [11:0] leds);
        logic [23:0] w;
        w = '0;
        w[ST_TAG_HI:ST_TAG_LO] = STAT_TAG;
        w[ST_OVF] = ovf;
        w[ST_ADDR] = addr_e;
        w[ST_OP] = op_e;
        w[ST_BUSY] = busy;
        w[ST_SHOW] = show;
        w[ST_LEDS_HI:0] = leds;
        return w;
    endfunction
endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: SPI word, pixel RAM and frame driver signals around the command sequencer.
interface spi_cmd_ctrl_if;
    logic        mosi_rx;
    logic [23:0] mosi_data;
    logic        miso_tx;
    logic [23:0] miso_data;
    logic        pix_we;
    logic        pix_re;
    logic [11:0] pix_addr;
    logic [23:0] pix_wdata;
    logic [23:0] pix_rdata;
    logic        drv_busy;
    logic        refresh_start;

    modport master (
        input  mosi_rx, mosi_data, pix_rdata, drv_busy,
        output miso_tx, miso_data, pix_we, pix_re, pix_addr, pix_wdata, refresh_start
    );

    modport slave (
        output mosi_rx, mosi_data, pix_rdata, drv_busy,
        input  miso_tx, miso_data, pix_we, pix_re, pix_addr, pix_wdata, refresh_start
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI command words into pixel RAM accesses, status replies and refresh requests.
module spi_cmd_ctrl
    import ws2812_spi_pkg::*;
#(
    parameter int NUM_LEDS = 256,
    parameter int MIN_GAP  = 4
) (
    input logic            clk_sb,
    input logic            rst,
    spi_cmd_ctrl_if.master bus
);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [GW-1:0] GAP  = GW'(MIN_GAP);
    localparam logic [12:0]   LEDS = 13'(NUM_LEDS);
    localparam logic [11:0]   LAST = 12'(NUM_LEDS - 1);

    state_t        state, state_n;
    logic [11:0]   cur, cur_n, cur_inc;
    logic [7:0]    rem, rem_n;
    logic [GW-1:0] since_rx;
    logic          err_ovf, err_addr, err_op, show_pending;
    logic [3:0]    op;
    logic [11:0]   addr;
    logic [7:0]    cnt;
    logic          ovf, acc, hdr, rw, bad_addr, last;
    logic          pix_we_n, pix_re_n, miso_tx_n, stat, show_set, fire, op_err, addr_err;
    logic [11:0]   pix_addr_n;
    logic [23:0]   pix_wdata_n, miso_data_n;

    assign op       = bus.mosi_data[HDR_OP_HI:HDR_OP_LO];
    assign addr     = bus.mosi_data[HDR_ADDR_HI:HDR_ADDR_LO];
    assign cnt      = bus.mosi_data[HDR_CNT_HI:HDR_CNT_LO];
    // A word arriving too soon or while a read is still in flight is dropped.
    assign ovf      = bus.mosi_rx && (since_rx < GAP || state == S_RD_FETCH || state == S_RD_LOAD);
    assign acc      = bus.mosi_rx && !ovf;
    assign hdr      = acc && state == S_IDLE;
    assign rw       = op == OP_WRITE || op == OP_READ;
    assign bad_addr = {1'b0, addr} >= LEDS;
    assign last     = rem == 8'd1;
    assign cur_inc  = cur == LAST ? 12'd0 : cur + 12'd1;

    always_ff @(posedge clk_sb or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        cur_n = cur;
        rem_n = rem;
        case (state)
            S_IDLE: if (hdr && rw && cnt != 8'd0) begin
                state_n = bad_addr ? S_DISCARD : op == OP_WRITE ? S_WR_DATA : S_RD_FETCH;
                cur_n = addr;
                rem_n = cnt;
            end
            S_WR_DATA: if (acc) begin
                cur_n = cur_inc;
                rem_n = rem - 8'd1;
                state_n = last ? S_IDLE : S_WR_DATA;
            end
            S_RD_FETCH: state_n = S_RD_LOAD;
            S_RD_LOAD:  state_n = S_RD_DATA;
            S_RD_DATA: if (acc) begin
                cur_n = last ? cur : cur_inc;
                rem_n = rem - 8'd1;
                state_n = last ? S_IDLE : S_RD_FETCH;
            end
            S_DISCARD: if (acc) begin
                rem_n = rem - 8'd1;
                state_n = last ? S_IDLE : S_DISCARD;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pix_we_n    = state == S_WR_DATA && acc;
        pix_re_n    = state_n == S_RD_FETCH;
        pix_addr_n  = pix_we_n ? cur : pix_re_n ? cur_n : bus.pix_addr;
        pix_wdata_n = pix_we_n ? bus.mosi_data : bus.pix_wdata;
        stat        = hdr && op == OP_STATUS;
        miso_tx_n   = stat || state == S_RD_LOAD;
        miso_data_n = stat ? status_word(err_ovf, err_addr, err_op, bus.drv_busy, show_pending, LEDS[11:0])
                    : state == S_RD_LOAD ? bus.pix_rdata : bus.miso_data;
        show_set    = hdr && op == OP_SHOW;
        fire        = show_pending && !bus.drv_busy && !bus.refresh_start;
        op_err      = hdr && !(op inside {OP_WRITE, OP_READ, OP_SHOW, OP_STATUS});
        addr_err    = hdr && rw && bad_addr;
    end

    always_ff @(posedge clk_sb or posedge rst)
        if (rst) begin
            cur               <= '0;
            rem               <= '0;
            since_rx          <= GAP;
            err_ovf           <= 1'b0;
            err_addr          <= 1'b0;
            err_op            <= 1'b0;
            show_pending      <= 1'b0;
            bus.pix_we        <= 1'b0;
            bus.pix_re        <= 1'b0;
            bus.pix_addr      <= '0;
            bus.pix_wdata     <= '0;
            bus.miso_tx       <= 1'b0;
            bus.miso_data     <= '0;
            bus.refresh_start <= 1'b0;
        end else begin
            cur               <= cur_n;
            rem               <= rem_n;
            since_rx          <= bus.mosi_rx ? GW'(1) : since_rx == GAP ? GAP : since_rx + 1'b1;
            err_ovf           <= (err_ovf && !stat) || ovf;
            err_addr          <= (err_addr && !stat) || addr_err;
            err_op            <= (err_op && !stat) || op_err;
            // A SHOW landing on the cycle a frame starts is kept as a fresh request.
            show_pending      <= (show_pending && !fire) || show_set;
            bus.pix_we        <= pix_we_n;
            bus.pix_re        <= pix_re_n;
            bus.pix_addr      <= pix_addr_n;
            bus.pix_wdata     <= pix_wdata_n;
            bus.miso_tx       <= miso_tx_n;
            bus.miso_data     <= miso_data_n;
            bus.refresh_start <= fire;
        end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: word-level reference model feeds expectation queues; a negedge monitor checks DUT pulses.
module tb_spi_cmd_ctrl;
    localparam int N = 256;
    localparam int G = 4;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [23:0] data;
    } ev_t;

    logic clk_sb = 1'b0;
    logic rst = 1'b1;
    spi_cmd_ctrl_if bus();

    spi_cmd_ctrl #(.NUM_LEDS(N), .MIN_GAP(G)) dut (.clk_sb(clk_sb), .rst(rst), .bus(bus));

    always #5 clk_sb = ~clk_sb;

    ev_t wq[$];
    ev_t mq[$];
    int  rq[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    logic [23:0] ram[4096];
    bit          ram_v[4096];
    logic [23:0] ref_mem[4096];

    int m_mode, m_cur, m_rem, last_rx, last_fetch;
    bit m_ovf, m_addr, m_op, m_show, show_req, prev_fire, fire;

    function automatic logic [23:0] pat(int a);
        if (a == 16) return 24'h123456;
        if (a == 17) return 24'hABCDEF;
        return 24'(a * 32'h9E3779B1 >> 5);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_rem = 0;
        last_rx = -1000; last_fetch = -1000;
        m_ovf = 0; m_addr = 0; m_op = 0;
        m_show = 0; show_req = 0;
    endtask

    // Word-level interpretation of one received SPI word taking effect at clock edge e.
    task automatic model(logic [23:0] w, int e);
        logic [3:0] op;
        int a, c;
        bit ov;
        ov = (e - last_rx < G) || (m_mode == 2 && e - last_fetch <= 2);
        last_rx = e;
        if (ov) begin
            m_ovf = 1;
            return;
        end
        op = w[23:20]; a = int'(w[19:8]); c = int'(w[7:0]);
        case (m_mode)
            0: begin
                if (op == 4'h1 || op == 4'h2) begin
                    if (a >= N) begin
                        m_addr = 1;
                        if (c > 0) begin m_mode = 3; m_rem = c; end
                    end else if (c > 0) begin
                        m_cur = a; m_rem = c; m_mode = int'(op);
                        if (op == 4'h2) begin
                            mq.push_back('{e + 2, 12'd0, ref_mem[a]});
                            last_fetch = e;
                        end
                    end
                end else if (op == 4'h3) show_req = 1;
                else if (op == 4'h4) begin
                    mq.push_back('{e, 12'd0, {4'hA, m_ovf, m_addr, m_op, bus.drv_busy, m_show, 3'b000, 12'(N)}});
                    m_ovf = 0; m_addr = 0; m_op = 0;
                end else m_op = 1;
            end
            1: begin
                ref_mem[m_cur] = w;
                wq.push_back('{e, 12'(m_cur), w});
                m_cur = (m_cur + 1) % N;
                m_rem--;
                if (m_rem == 0) m_mode = 0;
            end
            2: begin
                m_rem--;
                if (m_rem == 0) m_mode = 0;
                else begin
                    m_cur = (m_cur + 1) % N;
                    mq.push_back('{e + 2, 12'd0, ref_mem[m_cur]});
                    last_fetch = e;
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic send(logic [23:0] w, int gap);
        bus.mosi_rx = 1'b1;
        bus.mosi_data = w;
        model(w, cyc + 1);
        @(negedge clk_sb);
        bus.mosi_rx = 1'b0;
        repeat (gap - 1) @(negedge clk_sb);
    endtask

    function automatic int rgap();
        return ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 6));
    endfunction

    task automatic check_idle(string tag);
        chk({tag, " miso_tx"}, 32'(bus.miso_tx), 0);
        chk({tag, " miso_data"}, 32'(bus.miso_data), 0);
        chk({tag, " pix_we"}, 32'(bus.pix_we), 0);
        chk({tag, " pix_re"}, 32'(bus.pix_re), 0);
        chk({tag, " pix_addr"}, 32'(bus.pix_addr), 0);
        chk({tag, " pix_wdata"}, 32'(bus.pix_wdata), 0);
        chk({tag, " refresh_start"}, 32'(bus.refresh_start), 0);
    endtask

    // Pixel RAM with one-cycle read latency.
    always @(posedge clk_sb) begin
        if (bus.pix_we) begin
            ram[bus.pix_addr] <= bus.pix_wdata;
            ram_v[bus.pix_addr] <= 1'b1;
        end
        if (bus.pix_re) bus.pix_rdata <= ram_v[bus.pix_addr] ? ram[bus.pix_addr] : pat(int'(bus.pix_addr));
    end

    // Frame-start scheduling: one start per pending request while the driver is idle, never back to back.
    always @(posedge clk_sb) begin
        cyc++;
        if (rst) prev_fire = 0;
        else begin
            fire = m_show && !bus.drv_busy && !prev_fire;
            if (fire) rq.push_back(cyc);
            m_show = (m_show && !fire) || show_req;
            show_req = 0;
            prev_fire = fire;
        end
    end

    always @(negedge clk_sb) if (!rst) begin
        ev_t ev;
        if (bus.pix_we) begin
            if (wq.size() == 0) chk("pix_we unexpected", 32'(bus.pix_we), 0);
            else begin
                ev = wq.pop_front();
                chk("pix_we cycle", cyc, ev.cyc);
                chk("pix_addr", 32'(bus.pix_addr), 32'(ev.addr));
                chk("pix_wdata", 32'(bus.pix_wdata), 32'(ev.data));
            end
        end
        if (bus.miso_tx) begin
            if (mq.size() == 0) chk("miso_tx unexpected", 32'(bus.miso_tx), 0);
            else begin
                ev = mq.pop_front();
                chk("miso_tx cycle", cyc, ev.cyc);
                chk("miso_data", 32'(bus.miso_data), 32'(ev.data));
            end
        end
        if (bus.refresh_start) begin
            if (rq.size() == 0) chk("refresh_start unexpected", 32'(bus.refresh_start), 0);
            else chk("refresh_start cycle", cyc, rq.pop_front());
        end
        if (wq.size() != 0 && wq[0].cyc < cyc) chk("pix_we missed", cyc, wq.pop_front().cyc);
        if (mq.size() != 0 && mq[0].cyc < cyc) chk("miso_tx missed", cyc, mq.pop_front().cyc);
        if (rq.size() != 0 && rq[0] < cyc) chk("refresh_start missed", cyc, rq.pop_front());
    end

    initial begin
        int t, c;
        logic [11:0] a;
        logic [3:0] o;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        model_reset();
        bus.mosi_rx = 1'b0;
        bus.mosi_data = '0;
        bus.drv_busy = 1'b0;
        repeat (3) @(negedge clk_sb);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk_sb);

        send(24'h100503, 4);
        send(24'h00FF00, 4);
        send(24'hFF0000, 4);
        send(24'h0000FF, 4);
        send(24'h10FF02, 4);
        send(24'h111111, 4);
        send(24'h222222, 4);
        send(24'h201002, 4);
        send(24'h000000, 4);
        send(24'h000000, 6);
        send(24'h120002, 4);
        send(24'h333333, 4);
        send(24'h444444, 4);
        send(24'h400000, 4);
        send(24'h400000, 4);

        bus.drv_busy = 1'b1;
        send(24'h300000, 4);
        send(24'h400000, 4);
        send(24'h300000, 4);
        repeat (38) @(negedge clk_sb);
        bus.drv_busy = 1'b0;
        repeat (10) @(negedge clk_sb);

        send(24'h100A03, 4);
        send(24'h5A5A5A, 4);
        #2 rst = 1'b1;
        #1 check_idle("mid reset");
        model_reset();
        repeat (2) @(negedge clk_sb);
        rst = 1'b0;
        send(24'h400000, 6);

        for (int k = 0; k < 300; k++) begin
            t = int'($urandom_range(0, 9));
            c = int'($urandom_range(0, 4));
            a = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(256, 4095)) : 12'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) bus.drv_busy = ~bus.drv_busy;
            o = t < 3 ? 4'h1 : t < 6 ? 4'h2 : t == 6 ? 4'h3 : t == 7 ? 4'h4
              : t == 8 ? 4'($urandom_range(5, 15)) : 4'h0;
            send({o, a, 8'(c)}, rgap());
            if (t < 6) for (int j = 0; j < c; j++) send(24'($urandom), rgap());
        end

        bus.drv_busy = 1'b0;
        repeat (10) @(negedge clk_sb);
        send(24'h400000, 6);
        send(24'h400000, 10);
        chk("pending pix_we", wq.size(), 0);
        chk("pending miso_tx", mq.size(), 0);
        chk("pending refresh_start", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer on the clk_sb domain between spi_slave and the WS2812 pixel RAM / refresh driver.
- Decodes 24-bit words delivered by spi_slave (mosi_rx / mosi_data_out) into pixel writes, pixel reads, status reads and refresh requests.
- Loads response words back into spi_slave (miso_tx / miso_data_in) for the next SPI transaction.
- Owns the pixel RAM write/read port and the driver start handshake.

Parameters:
- NUM_LEDS, 256, number of pixels; legal range 1..4096.
- MIN_GAP, 4, minimum clk_sb cycles between mosi_rx pulses; a closer pulse is an overrun.

Ports:
- clk_sb  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mosi_rx  in  1  one-cycle pulse; mosi_data valid.
- mosi_data  in  24  word received from spi_slave mosi_data_out.
- miso_tx  out  1  one-cycle pulse; loads miso_data into spi_slave.
- miso_data  out  24  response word to spi_slave miso_data_in.
- pix_we  out  1  pixel RAM write strobe.
- pix_re  out  1  pixel RAM read strobe.
- pix_addr  out  12  pixel RAM address.
- pix_wdata  out  24  GRB pixel to write.
- pix_rdata  in  24  GRB pixel; valid 1 cycle after pix_re.
- drv_busy  in  1  WS2812 driver currently shifting a frame.
- refresh_start  out  1  one-cycle pulse; starts a frame.

Behaviour:
- Reset (async, any time, including mid-command): state IDLE; miso_tx=0, miso_data=0, pix_we=0, pix_re=0, pix_addr=0, pix_wdata=0, refresh_start=0; remaining=0; show_pending=0; all error flags=0.
- Header word fields: [23:20] opcode, [19:8] addr, [7:0] count.
  - Opcodes: 1 WRITE, 2 READ, 3 SHOW, 4 STATUS. Any other value sets err_op and is ignored; state stays IDLE.
- Header decoded in the cycle after mosi_rx.
- Address check (WRITE/READ): addr >= NUM_LEDS sets err_addr.
  - count>0: go to DISCARD and consume count words with no RAM access.
  - count=0: stay IDLE.
- States:
  - IDLE: waits for a header.
  - WR_DATA:
    - Each mosi_rx at cycle T gives pix_we=1, pix_addr=cur, pix_wdata=mosi_data at T+1 (one cycle).
    - cur increments; remaining decrements.
    - remaining hits 0 -> IDLE.
  - RD_FETCH: pix_re=1, pix_addr=cur for one cycle -> RD_LOAD.
  - RD_LOAD: miso_data=pix_rdata, miso_tx=1 for one cycle -> RD_DATA.
  - RD_DATA:
    - Each mosi_rx (content ignored) decrements remaining.
    - remaining 0 -> IDLE.
    - Otherwise cur increments -> RD_FETCH.
    - Header mosi_rx at T gives miso_tx at T+3.
    - Exactly count words are loaded.
  - DISCARD: counts down remaining on mosi_rx -> IDLE.
  - WRITE/READ with count=0: no RAM access; stay IDLE.
- Address wrap: cur = NUM_LEDS-1 increments to 0.
- STATUS:
  - Cycle T+1 after the header: miso_data = {4'hA, err_ovf, err_addr, err_op, drv_busy, show_pending, 3'b0, NUM_LEDS[11:0]}, miso_tx=1.
  - The three error flags clear in the same cycle.
  - An error event in that same cycle wins: the flag stays set.
- SHOW is independent of the state machine and is accepted only from IDLE:
  - Sets show_pending.
  - Each cycle with show_pending=1 and drv_busy=0: refresh_start=1 for one cycle; show_pending clears.
  - SHOW while pending merges into the single pending request.
  - refresh_start is never asserted in two consecutive cycles.
- Overrun: mosi_rx fewer than MIN_GAP cycles after the previous one, or during RD_FETCH/RD_LOAD.
  - Sets err_ovf; the word is dropped; state is unchanged.
- Outputs pix_we, pix_re, miso_tx and refresh_start are registered single-cycle pulses.

Decomposition:
- Package ws2812_spi_pkg holds:
  - opcode constants (OP_WRITE=4'h1, OP_READ=4'h2, OP_SHOW=4'h3, OP_STATUS=4'h4);
  - state encoding;
  - header field bit positions;
  - status word bit positions and the 4'hA tag.
- No sub-module is needed; the show scheduler is about 15 lines and stays inline.

Test Plan:
- WRITE header 0x1_005_03 then 0x00FF00, 0xFF0000, 0x0000FF -> pix_we pulses at addr 5, 6, 7 with those data, one cycle after each mosi_rx; then back in IDLE.
- WRITE 0x1_0FF_02 with NUM_LEDS=256 -> writes at addr 255 then 0 (wrap).
- READ 0x2_010_02 with RAM[16]=0x123456, RAM[17]=0xABCDEF -> miso_tx 3 cycles after the header with 0x123456; after the next mosi_rx, 0xABCDEF; after the final mosi_rx, IDLE with no further miso_tx.
- WRITE 0x1_200_02 (addr 512 >= 256) -> no pix_we; two words discarded. Then STATUS -> miso_data 0xA4_0100 (err_addr only); a second STATUS -> 0xA0_0100.
- SHOW with drv_busy=1 for 50 cycles, plus a second SHOW during that time -> show_pending=1; exactly one refresh_start, in the first cycle after drv_busy falls.
- Assert rst in WR_DATA with remaining=2 -> all outputs 0 immediately; the next word is decoded as a header.
